// File: rtl/bank_htu_set_nway.sv
// One cache set of the bank HTU: per-way tag and sector state plus a tree-PLRU.
// The lookup is combinational, and the state, tag and PLRU updates commit on the next clock edge.
module bank_htu_set_nway #(
  parameter  int NUM_WAYS = 8,
  parameter  int TAG_W    = 22,
  parameter  int SECTORS  = 2,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SEC_W    = (SECTORS > 1) ? $clog2(SECTORS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [1:0]             req_op_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  input  logic [SEC_W-1:0]       req_sector_i,
  input  logic [NUM_WAYS-1:0]    way_en_i,
  output logic                   hit_o,
  output logic [WAY_W-1:0]       way_o,
  output logic                   alloc_o,
  output logic                   no_alloc_o,
  output logic [2*SECTORS-1:0]   line_state_o,
  output logic                   evict_o,
  output logic [TAG_W-1:0]       evict_tag_o
);

  localparam logic [1:0] S_INV   = 2'b00;
  localparam logic [1:0] S_CLEAN = 2'b01;
  localparam logic [1:0] S_DIRTY = 2'b10;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_INVAL = 2'd3
  } op_e;

  logic [2*SECTORS-1:0] state_q [NUM_WAYS];
  logic [2*SECTORS-1:0] state_d [NUM_WAYS];
  logic [TAG_W-1:0]     tag_q   [NUM_WAYS];
  logic [TAG_W-1:0]     tag_d   [NUM_WAYS];
  logic [NUM_WAYS-2:0]  plru_q, plru_d;

  function automatic logic line_dirty(input logic [2*SECTORS-1:0] l);
    logic d;
    d = 1'b0;
    for (int k = 0; k < SECTORS; k++) d = d | (l[2*k +: 2] == S_DIRTY);
    return d;
  endfunction

  function automatic logic [2*SECTORS-1:0] flush_line(input logic [2*SECTORS-1:0] l);
    logic [2*SECTORS-1:0] r;
    for (int k = 0; k < SECTORS; k++) r[2*k +: 2] = (l[2*k +: 2] == S_DIRTY) ? S_CLEAN : l[2*k +: 2];
    return r;
  endfunction

  function automatic logic [1:0] get_sector(input logic [2*SECTORS-1:0] l, input logic [SEC_W-1:0] s);
    logic [1:0] r;
    r = S_INV;
    for (int k = 0; k < SECTORS; k++) r = (k == int'(s)) ? l[2*k +: 2] : r;
    return r;
  endfunction

  function automatic logic [2*SECTORS-1:0] set_sector(input logic [2*SECTORS-1:0] l,
                                                      input logic [SEC_W-1:0] s, input logic [1:0] v);
    logic [2*SECTORS-1:0] r;
    for (int k = 0; k < SECTORS; k++) r[2*k +: 2] = (k == int'(s)) ? v : l[2*k +: 2];
    return r;
  endfunction

  // Walk from the root; a node bit of 0 steers towards the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] p);
    logic [WAY_W-1:0] v;
    logic b;
    int node;
    v = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < NUM_WAYS-1; n++) b = (n == node) ? p[n] : b;
      v[WAY_W-1-l] = b;
      node = 2*node + 1 + (b ? 1 : 0);
    end
    return v;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] p, input logic [WAY_W-1:0] w);
    logic [NUM_WAYS-2:0] r;
    logic d;
    int node;
    r = p;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d = w[WAY_W-1-l];
      for (int n = 0; n < NUM_WAYS-1; n++) r[n] = (n == node) ? ~d : r[n];
      node = 2*node + 1 + (d ? 1 : 0);
    end
    return r;
  endfunction

  op_e                 op_s;
  logic                rw_s, any_hit_s;
  logic [NUM_WAYS-1:0] hit_vec_s, inv_en_s;
  logic [WAY_W-1:0]    hit_way_s, inv_way_s, first_en_s, plru_way_s, victim_s, sel_way_s;
  logic [1:0]          cur_sec_s;

  assign op_s = op_e'(req_op_i);
  assign rw_s = (op_s == OP_READ) || (op_s == OP_WRITE);

  // Descending scans leave the lowest-index match in each selector.
  always_comb begin
    hit_vec_s  = '0;
    inv_en_s   = '0;
    hit_way_s  = '0;
    inv_way_s  = '0;
    first_en_s = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      hit_vec_s[w] = (|state_q[w]) && (tag_q[w] == req_tag_i);
      inv_en_s[w]  = ~(|state_q[w]) && way_en_i[w];
      hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
      inv_way_s    = inv_en_s[w]  ? WAY_W'(w) : inv_way_s;
      first_en_s   = way_en_i[w]  ? WAY_W'(w) : first_en_s;
    end
  end

  assign any_hit_s  = |hit_vec_s;
  assign plru_way_s = plru_victim(plru_q);
  assign victim_s   = (|inv_en_s) ? inv_way_s : (way_en_i[plru_way_s] ? plru_way_s : first_en_s);
  assign sel_way_s  = any_hit_s ? hit_way_s : victim_s;
  assign cur_sec_s  = get_sector(state_q[hit_way_s], req_sector_i);

  assign hit_o        = req_valid_i & any_hit_s;
  assign way_o        = req_valid_i ? sel_way_s : '0;
  assign alloc_o      = req_valid_i & rw_s & ~any_hit_s & (|way_en_i);
  assign no_alloc_o   = req_valid_i & rw_s & ~any_hit_s & ~(|way_en_i);
  assign line_state_o = req_valid_i ? state_q[sel_way_s] : '0;
  assign evict_o      = alloc_o & line_dirty(state_q[victim_s]);
  assign evict_tag_o  = req_valid_i ? tag_q[sel_way_s] : '0;

  // Next-state for sectors, tags and PLRU.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    plru_d  = plru_q;
    if (req_valid_i) begin
      case (op_s)
        OP_READ, OP_WRITE: begin
          if (any_hit_s) begin
            state_d[hit_way_s] = set_sector(state_q[hit_way_s], req_sector_i,
                                            (op_s == OP_WRITE) ? S_DIRTY :
                                            ((cur_sec_s == S_INV) ? S_CLEAN : cur_sec_s));
            plru_d = plru_touch(plru_q, hit_way_s);
          end else if (|way_en_i) begin
            tag_d[victim_s]   = req_tag_i;
            state_d[victim_s] = set_sector('0, req_sector_i, (op_s == OP_WRITE) ? S_DIRTY : S_CLEAN);
            plru_d = plru_touch(plru_q, victim_s);
          end else begin
            plru_d = plru_q;
          end
        end
        OP_FLUSH: begin
          if (any_hit_s) state_d[hit_way_s] = flush_line(state_q[hit_way_s]);
          else           plru_d = plru_q;
        end
        OP_INVAL: begin
          if (any_hit_s) state_d[hit_way_s] = '0;
          else           plru_d = plru_q;
        end
        default: plru_d = plru_q;
      endcase
    end else begin
      plru_d = plru_q;
    end
  end

  // State registers; reset overrides any concurrent request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        state_q[w] <= '0;
        tag_q[w]   <= '0;
      end
      plru_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        state_q[w] <= state_d[w];
        tag_q[w]   <= tag_d[w];
      end
      plru_q <= plru_d;
    end
  end

endmodule

// File: tb/tb_bank_htu_set_nway.sv
// Directed bench for bank_htu_set_nway (8 ways, 2 sectors).
// Expected values are hand-derived from the sector and PLRU rules.
module tb_bank_htu_set_nway;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, FL = 2'd2, IV = 2'd3;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_sector;
  logic [1:0]  req_op;
  logic [21:0] req_tag, evict_tag;
  logic [7:0]  way_en;
  logic        hit, alloc, no_alloc, evict;
  logic [2:0]  way;
  logic [3:0]  line_state;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bank_htu_set_nway dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_op_i(req_op),
    .req_tag_i(req_tag), .req_sector_i(req_sector), .way_en_i(way_en),
    .hit_o(hit), .way_o(way), .alloc_o(alloc), .no_alloc_o(no_alloc),
    .line_state_o(line_state), .evict_o(evict), .evict_tag_o(evict_tag)
  );

  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [21:0] tag, input logic sec, input logic [7:0] en);
    @(negedge clk);
    rst = r; req_valid = v; req_op = op; req_tag = tag; req_sector = sec; way_en = en;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic look(input string n, input logic h, input logic [2:0] w, input logic a,
                      input logic e, input logic [21:0] et, input logic [3:0] ls);
    chk({n, "_hit"}, 32'(hit), 32'(h));
    chk({n, "_way"}, 32'(way), 32'(w));
    chk({n, "_alloc"}, 32'(alloc), 32'(a));
    chk({n, "_evict"}, 32'(evict), 32'(e));
    chk({n, "_evtag"}, 32'(evict_tag), 32'(et));
    chk({n, "_state"}, 32'(line_state), 32'(ls));
  endtask

  task automatic idle_chk(input string n);
    look(n, 1'b0, 3'd0, 1'b0, 1'b0, 22'h0, 4'h0);
    chk({n, "_noalloc"}, 32'(no_alloc), 32'h0);
  endtask

  initial begin
    drive(1'b1, 1'b0, RD, 22'h0, 1'b0, 8'h00);
    idle_chk("in_reset");
    drive(1'b1, 1'b0, RD, 22'h0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, RD, 22'h0, 1'b0, 8'h00);
    idle_chk("after_reset");

    // Fill the set: victims are the invalid ways in index order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, RD, 22'(16 + i), 1'b0, 8'hFF);
      look("fill", 1'b0, 3'(i), 1'b1, 1'b0, 22'h0, 4'b0000);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, FL, 22'(16 + i), 1'b0, 8'hFF);
      look("probe", 1'b1, 3'(i), 1'b0, 1'b0, 22'(16 + i), 4'b0001);
    end

    drive(1'b0, 1'b1, RD, 22'h99, 1'b0, 8'hFF);
    look("plru_miss", 1'b0, 3'd0, 1'b1, 1'b0, 22'h10, 4'b0001);
    drive(1'b0, 1'b1, WR, 22'h12, 1'b1, 8'hFF);
    look("wr_hit", 1'b1, 3'd2, 1'b0, 1'b0, 22'h12, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h12, 1'b1, 8'hFF);
    look("rd_after_wr", 1'b1, 3'd2, 1'b0, 1'b0, 22'h12, 4'b1001);

    // Dirty way 0, then steer the PLRU back to it via ways 1, 3, 4.
    drive(1'b0, 1'b1, WR, 22'h99, 1'b0, 8'hFF);
    look("wr_way0", 1'b1, 3'd0, 1'b0, 1'b0, 22'h99, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h11, 1'b0, 8'hFF);
    look("touch1", 1'b1, 3'd1, 1'b0, 1'b0, 22'h11, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h13, 1'b0, 8'hFF);
    look("touch3", 1'b1, 3'd3, 1'b0, 1'b0, 22'h13, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h14, 1'b0, 8'hFF);
    look("touch4", 1'b1, 3'd4, 1'b0, 1'b0, 22'h14, 4'b0001);
    drive(1'b0, 1'b1, WR, 22'h55, 1'b1, 8'hFF);
    look("evict", 1'b0, 3'd0, 1'b1, 1'b1, 22'h99, 4'b0010);

    drive(1'b0, 1'b1, RD, 22'h99, 1'b0, 8'h00);
    chk("old_tag_hit", 32'(hit), 32'h0);
    chk("no_alloc", 32'(no_alloc), 32'h1);
    chk("no_alloc_alloc", 32'(alloc), 32'h0);
    chk("no_alloc_evict", 32'(evict), 32'h0);
    drive(1'b0, 1'b1, RD, 22'h55, 1'b1, 8'hFF);
    look("new_line", 1'b1, 3'd0, 1'b0, 1'b0, 22'h55, 4'b1000);

    drive(1'b0, 1'b1, WR, 22'h12, 1'b0, 8'hFF);
    look("dirty_both", 1'b1, 3'd2, 1'b0, 1'b0, 22'h12, 4'b1001);
    drive(1'b0, 1'b1, RD, 22'h16, 1'b0, 8'hFF);
    look("touch6", 1'b1, 3'd6, 1'b0, 1'b0, 22'h16, 4'b0001);
    drive(1'b0, 1'b1, FL, 22'h12, 1'b0, 8'hFF);
    look("flush", 1'b1, 3'd2, 1'b0, 1'b0, 22'h12, 4'b1010);
    // The PLRU still points at way 1 if the flush left it alone.
    drive(1'b0, 1'b1, RD, 22'h77, 1'b0, 8'hFF);
    look("plru_kept", 1'b0, 3'd1, 1'b1, 1'b0, 22'h11, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h12, 1'b0, 8'hFF);
    look("flushed", 1'b1, 3'd2, 1'b0, 1'b0, 22'h12, 4'b0101);

    drive(1'b0, 1'b1, IV, 22'h15, 1'b0, 8'hFF);
    look("inval", 1'b1, 3'd5, 1'b0, 1'b0, 22'h15, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h78, 1'b0, 8'hFF);
    look("realloc", 1'b0, 3'd5, 1'b1, 1'b0, 22'h15, 4'b0000);

    drive(1'b0, 1'b1, RD, 22'h80, 1'b0, 8'h80);
    look("en_80", 1'b0, 3'd7, 1'b1, 1'b0, 22'h17, 4'b0001);
    drive(1'b0, 1'b1, RD, 22'h80, 1'b0, 8'h00);
    look("hit_no_en", 1'b1, 3'd7, 1'b0, 1'b0, 22'h80, 4'b0001);
    chk("hit_no_en_noalloc", 32'(no_alloc), 32'h0);

    drive(1'b1, 1'b1, WR, 22'h3C, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, RD, 22'h3C, 1'b1, 8'hFF);
    look("rst_wins", 1'b0, 3'd0, 1'b1, 1'b0, 22'h0, 4'b0000);
    drive(1'b0, 1'b0, RD, 22'h3C, 1'b1, 8'hFF);
    idle_chk("idle_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
